rps_match_controller: RTL and testbench

Match sequencer for the rock-paper-scissors game engine. It turns the player's start button into timed rounds: a 3-2-1 countdown, then a capture of both players' choices. It hands the captured choices to the evaluation engine through a start/done handshake and keeps both scores. The match ends when one player reaches the winning score. It sits between the top-level pin mapping and the game engine, and its score, countdown and result outputs feed the seven-segment driver.

---
 rtl/rps_match_controller.sv | 217 +++++++++++++++++++++
 tb/tb_rps_match_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_match_controller.sv
// rtl/rps_match_controller.sv - rock-paper-scissors match sequencer
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start_btn             clean level; a rising edge requests a match start
//   p1_choice, p2_choice  player choices, captured on the edge entering LATCH
//   eval_start            one-cycle request to the evaluation engine
//   eval_p1, eval_p2      latched choices presented to the engine
//   eval_done             engine response strobe, honoured only in WAIT
//   eval_result           00 draw, 01 P1 wins, 10 P2 wins, 11 invalid
//   countdown             3/2/1 during COUNTDOWN, 0 otherwise
//   round_result          last recorded engine result, cleared at LATCH
//   p1_score, p2_score    current scores, saturating at WIN_SCORE
//   match_winner          00 none, 01 P1, 10 P2
//   busy                  high in every state except IDLE and OVER
//   error                 engine timeout flag, sticky until the next start
module rps_match_controller #(
   parameter int CNT_TICKS    = 10_000_000,
   parameter int SHOW_TICKS   = 20_000_000,
   parameter int WIN_SCORE    = 3,
   parameter int EVAL_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic [1:0] p1_choice,
   input  logic [1:0] p2_choice,
   output logic       eval_start,
   output logic [1:0] eval_p1,
   output logic [1:0] eval_p2,
   input  logic       eval_done,
   input  logic [1:0] eval_result,
   output logic [1:0] countdown,
   output logic [1:0] round_result,
   output logic [2:0] p1_score,
   output logic [2:0] p2_score,
   output logic [1:0] match_winner,
   output logic       busy,
   output logic       error
);

   localparam logic [31:0] CNT_LAST  = 32'(CNT_TICKS - 1);
   localparam logic [31:0] SHOW_LAST = 32'(SHOW_TICKS - 1);
   localparam logic [31:0] TO_LAST   = 32'(EVAL_TIMEOUT - 1);
   localparam logic [2:0]  WIN       = 3'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNTDOWN,
      S_LATCH,
      S_WAIT,
      S_SHOW,
      S_OVER
   } state_t;

   state_t      state_q, state_d;
   logic        btn_prev_q;
   // One counter serves the countdown step, the engine timeout and the
   // result display, since only one of them is active in any state.
   logic [31:0] tick_q, tick_d;
   logic [1:0]  countdown_q, countdown_d;
   logic        eval_start_q, eval_start_d;
   logic [1:0]  eval_p1_q, eval_p1_d;
   logic [1:0]  eval_p2_q, eval_p2_d;
   logic [1:0]  round_result_q, round_result_d;
   logic [2:0]  p1_score_q, p1_score_d;
   logic [2:0]  p2_score_q, p2_score_d;
   logic [1:0]  match_winner_q, match_winner_d;
   logic        busy_q, busy_d;
   logic        error_q, error_d;
   logic        start_edge;

   // btn_prev_q resets high so a button held through reset is not an edge.
   assign start_edge = start_btn & ~btn_prev_q;

   always_comb begin
      state_d        = state_q;
      tick_d         = tick_q;
      countdown_d    = countdown_q;
      eval_start_d   = 1'b0;
      eval_p1_d      = eval_p1_q;
      eval_p2_d      = eval_p2_q;
      round_result_d = round_result_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      match_winner_d = match_winner_q;
      error_d        = error_q;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_edge) begin
               p1_score_d     = 3'd0;
               p2_score_d     = 3'd0;
               match_winner_d = 2'b00;
               error_d        = 1'b0;
               countdown_d    = 2'd3;
               tick_d         = 32'd0;
               state_d        = S_COUNTDOWN;
            end
         end

         S_COUNTDOWN: begin
            if (tick_q == CNT_LAST) begin
               tick_d = 32'd0;
               if (countdown_q == 2'd1) begin
                  // Outputs for LATCH are set on the edge entering it so
                  // eval_start and the captured choices appear together.
                  countdown_d    = 2'd0;
                  eval_start_d   = 1'b1;
                  eval_p1_d      = p1_choice;
                  eval_p2_d      = p2_choice;
                  round_result_d = 2'b00;
                  state_d        = S_LATCH;
               end else begin
                  countdown_d = countdown_q - 2'd1;
               end
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end

         S_LATCH: begin
            tick_d  = 32'd0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (eval_done) begin
               round_result_d = eval_result;
               if (eval_result == 2'b01 && p1_score_q != WIN) begin
                  p1_score_d = p1_score_q + 3'd1;
               end
               if (eval_result == 2'b10 && p2_score_q != WIN) begin
                  p2_score_d = p2_score_q + 3'd1;
               end
               tick_d  = 32'd0;
               state_d = S_SHOW;
            end else if (tick_q == TO_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end

         S_SHOW: begin
            if (tick_q == SHOW_LAST) begin
               tick_d = 32'd0;
               if (p1_score_q == WIN) begin
                  match_winner_d = 2'b01;
                  state_d        = S_OVER;
               end else if (p2_score_q == WIN) begin
                  match_winner_d = 2'b10;
                  state_d        = S_OVER;
               end else begin
                  countdown_d = 2'd3;
                  state_d     = S_COUNTDOWN;
               end
            end else begin
               tick_d = tick_q + 32'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy is registered from the next state so it tracks the state
      // register without a combinational path to the outputs.
      busy_d = (state_d != S_IDLE) && (state_d != S_OVER);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         btn_prev_q     <= 1'b1;
         tick_q         <= 32'd0;
         countdown_q    <= 2'd0;
         eval_start_q   <= 1'b0;
         eval_p1_q      <= 2'b00;
         eval_p2_q      <= 2'b00;
         round_result_q <= 2'b00;
         p1_score_q     <= 3'd0;
         p2_score_q     <= 3'd0;
         match_winner_q <= 2'b00;
         busy_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         btn_prev_q     <= start_btn;
         tick_q         <= tick_d;
         countdown_q    <= countdown_d;
         eval_start_q   <= eval_start_d;
         eval_p1_q      <= eval_p1_d;
         eval_p2_q      <= eval_p2_d;
         round_result_q <= round_result_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         match_winner_q <= match_winner_d;
         busy_q         <= busy_d;
         error_q        <= error_d;
      end
   end

   assign eval_start   = eval_start_q;
   assign eval_p1      = eval_p1_q;
   assign eval_p2      = eval_p2_q;
   assign countdown    = countdown_q;
   assign round_result = round_result_q;
   assign p1_score     = p1_score_q;
   assign p2_score     = p2_score_q;
   assign match_winner = match_winner_q;
   assign busy         = busy_q;
   assign error        = error_q;

endmodule

// File: tb/tb_rps_match_controller.sv
// tb/tb_rps_match_controller.sv - scoreboard bench for rps_match_controller
module tb_rps_match_controller;

   localparam int CNT  = 2;
   localparam int SHOW = 3;
   localparam int WINS = 2;
   localparam int TO   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_btn;
   logic [1:0] p1_choice, p2_choice;
   logic       eval_start;
   logic [1:0] eval_p1, eval_p2;
   logic       eval_done;
   logic [1:0] eval_result;
   logic [1:0] countdown, round_result, match_winner;
   logic [2:0] p1_score, p2_score;
   logic       busy, error;

   rps_match_controller #(
      .CNT_TICKS   (CNT),
      .SHOW_TICKS  (SHOW),
      .WIN_SCORE   (WINS),
      .EVAL_TIMEOUT(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_btn   (start_btn),
      .p1_choice   (p1_choice),
      .p2_choice   (p2_choice),
      .eval_start  (eval_start),
      .eval_p1     (eval_p1),
      .eval_p2     (eval_p2),
      .eval_done   (eval_done),
      .eval_result (eval_result),
      .countdown   (countdown),
      .round_result(round_result),
      .p1_score    (p1_score),
      .p2_score    (p2_score),
      .match_winner(match_winner),
      .busy        (busy),
      .error       (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [18:0] vec;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   bit end_req = 1'b0;
   bit end_done = 1'b0;

   // Expected output state, updated by hand in the stimulus.
   logic       m_es;
   logic [1:0] m_ep1, m_ep2, m_cd, m_rr, m_win;
   logic [2:0] m_s1, m_s2;
   logic       m_busy, m_err;
   logic [18:0] last_pushed = '1;

   logic [18:0] dut_vec;
   assign dut_vec = {eval_start, eval_p1, eval_p2, countdown, round_result,
                     p1_score, p2_score, match_winner, busy, error};

   function automatic logic [18:0] mvec();
      return {m_es, m_ep1, m_ep2, m_cd, m_rr, m_s1, m_s2, m_win, m_busy, m_err};
   endfunction

   task automatic push(input int at, input string name);
      exp_t e;
      if (mvec() != last_pushed) begin
         e.cyc  = at;
         e.vec  = mvec();
         e.name = name;
         exp_q.push_back(e);
         last_pushed = mvec();
      end
   endtask

   task automatic model_reset();
      m_es = 1'b0; m_ep1 = 2'b00; m_ep2 = 2'b00; m_cd = 2'd0; m_rr = 2'b00;
      m_s1 = 3'd0; m_s2 = 3'd0; m_win = 2'b00; m_busy = 1'b0; m_err = 1'b0;
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Monitor: every change of the output vector pops one expectation and
   // checks both its value and the cycle it appeared in.
   logic [18:0] prev_vec = '1;
   always @(negedge clk) begin
      exp_t e;
      if (dut_vec !== prev_vec) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change cyc=%0d got=%h", cyc, dut_vec);
         end else begin
            e = exp_q.pop_front();
            checks += 2;
            if (dut_vec !== e.vec) begin
               errors++;
               $display("FAIL %s value cyc=%0d got=%h expected=%h", e.name, cyc, dut_vec, e.vec);
            end
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL %s timing got_cyc=%0d expected_cyc=%0d", e.name, cyc, e.cyc);
            end
         end
         prev_vec = dut_vec;
      end
      if (end_req && !end_done) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got=%0d pending expected=0 next=%s", exp_q.size(), exp_q[0].name);
         end
         end_done = 1'b1;
      end
   end

   task automatic press(output int t0);
      int c;
      c = cyc;
      start_btn = 1'b1;
      m_s1 = 3'd0; m_s2 = 3'd0; m_win = 2'b00; m_err = 1'b0;
      m_cd = 2'd3; m_busy = 1'b1;
      push(c + 1, "start");
      t0 = c + 1;
      @(negedge clk);
      start_btn = 1'b0;
   endtask

   task automatic run_countdown(input int t0, input logic [1:0] c1, input logic [1:0] c2,
                                output int w);
      p1_choice = c1;
      p2_choice = c2;
      m_cd = 2'd2; push(t0 + CNT, "cd2");
      m_cd = 2'd1; push(t0 + 2 * CNT, "cd1");
      m_cd = 2'd0; m_es = 1'b1; m_ep1 = c1; m_ep2 = c2; m_rr = 2'b00;
      push(t0 + 3 * CNT, "latch");
      m_es = 1'b0; push(t0 + 3 * CNT + 1, "wait");
      w = t0 + 3 * CNT + 1;
   endtask

   task automatic engine(input int w, input int k, input logic [1:0] res,
                         input bit latch_pulse, output int nxt);
      int s;
      if (latch_pulse) begin
         wait_cyc(w - 1);
         eval_done = 1'b1; eval_result = 2'b01;
         @(negedge clk);
         eval_done = 1'b0; eval_result = 2'b00;
      end
      wait_cyc(w + k);
      eval_done = 1'b1;
      eval_result = res;
      m_rr = res;
      if (res == 2'b01 && m_s1 != 3'(WINS)) m_s1 = m_s1 + 3'd1;
      if (res == 2'b10 && m_s2 != 3'(WINS)) m_s2 = m_s2 + 3'd1;
      s = w + k + 1;
      push(s, "show");
      if (m_s1 == 3'(WINS)) begin
         m_win = 2'b01; m_busy = 1'b0;
      end else if (m_s2 == 3'(WINS)) begin
         m_win = 2'b10; m_busy = 1'b0;
      end else begin
         m_cd = 2'd3;
      end
      push(s + SHOW, "show_exit");
      nxt = s + SHOW;
      @(negedge clk);
      eval_done = 1'b0;
      eval_result = 2'b00;
   endtask

   int t0, w;

   initial begin
      rst = 1'b1; start_btn = 1'b1;
      p1_choice = 2'b00; p2_choice = 2'b00;
      eval_done = 1'b0; eval_result = 2'b00;
      model_reset();
      push(1, "reset");
      wait_cyc(4);
      rst = 1'b0;
      wait_cyc(8);
      start_btn = 1'b0;
      wait_cyc(10);

      // Match 1: P1 wins 2-0; stray start edges in COUNTDOWN and SHOW.
      press(t0);
      run_countdown(t0, 2'b00, 2'b10, w);
      @(negedge clk); start_btn = 1'b1;
      @(negedge clk); start_btn = 1'b0;
      engine(w, 2, 2'b01, 1'b0, t0);
      start_btn = 1'b1;
      @(negedge clk); start_btn = 1'b0;
      wait_cyc(t0);
      run_countdown(t0, 2'b01, 2'b00, w);
      wait_cyc(w);
      p1_choice = 2'b10;
      p2_choice = 2'b01;
      engine(w, 2, 2'b01, 1'b0, t0);
      wait_cyc(t0 + 3);

      // Match 2: draw, invalid, P2 point on the last WAIT cycle, then timeout.
      press(t0);
      run_countdown(t0, 2'b10, 2'b10, w);
      engine(w, 0, 2'b00, 1'b0, t0);
      run_countdown(t0, 2'b01, 2'b10, w);
      engine(w, 1, 2'b11, 1'b0, t0);
      run_countdown(t0, 2'b00, 2'b01, w);
      engine(w, TO - 1, 2'b10, 1'b0, t0);
      run_countdown(t0, 2'b10, 2'b00, w);
      m_err = 1'b1; m_busy = 1'b0;
      push(w + TO, "timeout");
      wait_cyc(w + TO + 2);

      // Match 3: start clears error; done during LATCH is ignored.
      press(t0);
      run_countdown(t0, 2'b01, 2'b10, w);
      engine(w, 1, 2'b10, 1'b1, t0);
      run_countdown(t0, 2'b00, 2'b00, w);
      wait_cyc(w + 1);
      rst = 1'b1;
      model_reset();
      push(w + 2, "mid_reset");
      @(negedge clk);
      rst = 1'b0;
      eval_done = 1'b1; eval_result = 2'b01;
      @(negedge clk);
      eval_done = 1'b0; eval_result = 2'b00;
      wait_cyc(cyc + 8);

      end_req = 1'b1;
      for (int i = 0; i < 4 && !end_done; i++) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
